reg_access_ctrl: RTL and testbench
==================================

// Module: reg_access_ctrl
// PURPOSE
//  Multi-cycle controller that drives the 4x8-bit register file's read/write port: accepts 8-bit
//  instructions via valid/ready, issues source reads, waits the registered read latency, computes
//  an 8-bit result and performs a single write-back cycle. Sits between instruction source and
//  register file; it is the initiator of every register file access.
// PARAMETERS
//  DATA_W    8  register/data width; all arithmetic is mod 2^DATA_W
//  READ_LAT  1  cycles from read address stable to READ_DATA_* valid (1..3); sets WAIT length
// PORTS
//  CLK             in   1       single clock, all state on posedge
//  RST             in   1       synchronous, active-high reset
//  INSTR_VALID     in   1       instruction offered
//  INSTR           in   8       [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd / imm
//  INSTR_READY     out  1       controller can accept (IDLE only)
//  READ_DATA_ONE   in   DATA_W  register file data for REG_SOURCE
//  READ_DATA_TWO   in   DATA_W  register file data for REG_TWO
//  REG_SOURCE      out  2       read address one (rs)
//  REG_TWO         out  2       read address two (rt); also write address when REGDST=0
//  REG_DEST        out  2       write address when REGDST=1 (rd)
//  REGDST          out  1       1: write rd, 0: write rt
//  REGWRITE        out  1       write strobe, high exactly one cycle per writing instruction
//  REG_WRITE_DATA  out  DATA_W  write-back value
//  CARRY           out  1       carry (ADD/ADDI) or borrow (SUB) of last executed op
//  DONE            out  1       one-cycle pulse in the cycle after WB
//  BUSY            out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset (sync): state=IDLE, INSTR_READY=1, all address outputs=0, REGDST=0, REGWRITE=0,
//    REG_WRITE_DATA=0, CARRY=0, DONE=0, BUSY=0, wait counter=0. Takes effect at the next edge
//    from any state; a WB in progress when RST is sampled is still written, later states are not.
//  - Handshake: transfer when INSTR_VALID & INSTR_READY at posedge; INSTR latched internally;
//    READY low from the following cycle until the controller returns to IDLE. INSTR ignored otherwise.
//  - FSM: IDLE -> READ (accept) -> WAIT (READ_LAT cycles, counter) -> EXEC -> WB -> IDLE.
//    READ: drive REG_SOURCE=rs, REG_TWO=rt. WAIT: hold; latch READ_DATA_* on last WAIT cycle.
//    EXEC: result/CARRY registered. WB: REGWRITE=1 (unless NOP), REG_WRITE_DATA=result.
//    DONE pulses in the IDLE cycle following WB; a new instruction may be accepted in that cycle.
//  - Addresses and REGDST held stable from READ through WB; 0 in IDLE. REGWRITE only in WB.
//  - Latency: write edge = 3+READ_LAT edges after accept edge; throughput 1 instr / (4+READ_LAT) cycles.
//  - Opcodes: 00 ADD  rd = rs + rt, REGDST=1, CARRY=carry out
//             01 SUB  rd = rs - rt, REGDST=1, CARRY=borrow (rs<rt unsigned)
//             10 ADDI rt = rs + sext(INSTR[1:0]) to DATA_W, REGDST=0, CARRY=carry out
//             11 NOP  full sequence, REGWRITE stays 0, CARRY unchanged, DONE still pulses
//  - rs==rt==rd aliasing legal: operands latched before write-back, no hazard within one op.
//  - Wrap-around: results truncated to DATA_W; 8'hFF+8'h01 -> 8'h00, CARRY=1.
// STRUCTURE
//  - Shared package/header: opcode constants OP_ADD/OP_SUB/OP_ADDI/OP_NOP, state encoding
//    S_IDLE/S_READ/S_WAIT/S_EXEC/S_WB, instruction field bit positions.
//  - One sub-module: alu8 (combinational: op, a, b, imm -> result, carry); FSM, operand and
//    result registers stay in reg_access_ctrl.
// TESTING (bench instantiates reg_access_ctrl + register file, both on CLK/RST)
//  1 RST 2 cycles -> all outputs at reset values, INSTR_READY=1; ADDI r1=r0+1 (8'b10_00_01_01)
//    -> REGWRITE one cycle, REG_TWO=1, REGDST=0, data 8'h01, DONE next cycle.
//  2 Build r1=1, r2=-1 via ADDI (imm 2'b11) -> r2=8'hFF; ADD r3=r1+r2 (8'b00_01_10_11) -> r3=8'h00, CARRY=1.
//  3 SUB r3=r1-r2 (8'b01_01_10_11) with r1=1,r2=FF -> r3=8'h02, CARRY=1; alias ADD r1=r1+r1 -> 8'h02.
//  4 Hold INSTR_VALID=1 back-to-back: exactly one accept per 4+READ_LAT cycles, no REGWRITE
//    while INSTR_READY=1; NOP 8'hC0 -> no REGWRITE, DONE pulses, register contents unchanged.
//  5 Assert RST in WAIT and in EXEC -> no REGWRITE follows, IDLE/reset outputs next edge.
//  6 READ_LAT=2 and 3 builds: write edge at 5 / 6 edges after accept; results identical to case 2.

Source files
------------

// File: rtl/reg_access_ctrl_pkg.sv
// Shared types for the register-file access controller: opcodes, FSM states and the instruction layout.
package reg_access_ctrl_pkg;

  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned REG_ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDI = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  // MSB first: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd (or imm for ADDI)
  typedef struct packed {
    op_e                   op;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } instr_t;

endpackage

// File: rtl/reg_access_ctrl_alu8.sv
// Combinational ALU: ADD/SUB/ADDI with carry (borrow for SUB); NOP yields zero.
module alu8
  import reg_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        imm,
  output logic [DATA_W-1:0] result_c,
  output logic              carry_c
);

  logic [DATA_W:0]   sum_c;
  logic [DATA_W-1:0] imm_ext_c;

  always_comb begin
    imm_ext_c = {{(DATA_W-2){imm[1]}}, imm};
    sum_c     = '0;
    case (op)
      OP_ADD:  sum_c = {1'b0, a} + {1'b0, b};
      // Top bit of the widened difference is the borrow (a < b unsigned)
      OP_SUB:  sum_c = {1'b0, a} - {1'b0, b};
      OP_ADDI: sum_c = {1'b0, a} + {1'b0, imm_ext_c};
      default: sum_c = '0;
    endcase
    result_c = sum_c[DATA_W-1:0];
    carry_c  = sum_c[DATA_W];
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Multi-cycle register-file initiator: accept instruction, read sources, wait read latency,
// execute, write back once, pulse DONE.
module reg_access_ctrl
  import reg_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INSTR_VALID,
  input  logic [INSTR_W-1:0]    INSTR,
  output logic                  INSTR_READY,
  input  logic [DATA_W-1:0]     READ_DATA_ONE,
  input  logic [DATA_W-1:0]     READ_DATA_TWO,
  output logic [REG_ADDR_W-1:0] REG_SOURCE,
  output logic [REG_ADDR_W-1:0] REG_TWO,
  output logic [REG_ADDR_W-1:0] REG_DEST,
  output logic                  REGDST,
  output logic                  REGWRITE,
  output logic [DATA_W-1:0]     REG_WRITE_DATA,
  output logic                  CARRY,
  output logic                  DONE,
  output logic                  BUSY
);

  localparam int unsigned    CNT_W     = 2;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_LAT - 1);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
  logic [REG_ADDR_W-1:0] src_d, two_d, dest_d;
  logic                  regdst_d, regwrite_d, carry_d, done_d, ready_d, busy_d;
  logic [DATA_W-1:0]     wdata_d;
  logic [DATA_W-1:0]     alu_result_c;
  logic                  alu_carry_c;
  instr_t                instr_in;

  assign instr_in = instr_t'(INSTR);

  // rd doubles as the ADDI immediate and is held on REG_DEST through EXEC
  alu8 #(.DATA_W(DATA_W)) u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .imm      (REG_DEST),
    .result_c (alu_result_c),
    .carry_c  (alu_carry_c)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    src_d      = REG_SOURCE;
    two_d      = REG_TWO;
    dest_d     = REG_DEST;
    regdst_d   = REGDST;
    regwrite_d = 1'b0;
    wdata_d    = REG_WRITE_DATA;
    carry_d    = CARRY;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (INSTR_VALID && INSTR_READY) begin
          op_d     = instr_in.op;
          src_d    = instr_in.rs;
          two_d    = instr_in.rt;
          dest_d   = instr_in.rd;
          regdst_d = (instr_in.op == OP_ADD) || (instr_in.op == OP_SUB);
          state_d  = S_READ;
        end
      end
      S_READ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          a_d     = READ_DATA_ONE;
          b_d     = READ_DATA_TWO;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (op_q != OP_NOP) begin
          wdata_d    = alu_result_c;
          carry_d    = alu_carry_c;
          regwrite_d = 1'b1;
        end
        state_d = S_WB;
      end
      S_WB: begin
        src_d    = '0;
        two_d    = '0;
        dest_d   = '0;
        regdst_d = 1'b0;
        cnt_d    = '0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      op_q           <= OP_NOP;
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      REG_SOURCE     <= '0;
      REG_TWO        <= '0;
      REG_DEST       <= '0;
      REGDST         <= 1'b0;
      REGWRITE       <= 1'b0;
      REG_WRITE_DATA <= '0;
      CARRY          <= 1'b0;
      DONE           <= 1'b0;
      INSTR_READY    <= 1'b1;
      BUSY           <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      REG_SOURCE     <= src_d;
      REG_TWO        <= two_d;
      REG_DEST       <= dest_d;
      REGDST         <= regdst_d;
      REGWRITE       <= regwrite_d;
      REG_WRITE_DATA <= wdata_d;
      CARRY          <= carry_d;
      DONE           <= done_d;
      INSTR_READY    <= ready_d;
      BUSY           <= busy_d;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl with a 4x8 register file of configurable read latency; scoreboard
// entries are pushed at each accept and retired on write-back / DONE.
module tb_reg_access_ctrl;

  parameter int unsigned READ_LAT = 1;

  typedef struct {
    logic       wr;
    logic       regdst;
    logic [1:0] rs;
    logic [1:0] addr;
    logic [7:0] data;
    logic       carry;
    int         acc;
  } sb_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INSTR_VALID = 1'b0;
  logic [7:0] INSTR = 8'h00;
  logic       INSTR_READY;
  logic [7:0] READ_DATA_ONE, READ_DATA_TWO;
  logic [1:0] REG_SOURCE, REG_TWO, REG_DEST;
  logic       REGDST, REGWRITE, CARRY, DONE, BUSY;
  logic [7:0] REG_WRITE_DATA;

  reg_access_ctrl #(.DATA_W(8), .READ_LAT(READ_LAT)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .INSTR_VALID    (INSTR_VALID),
    .INSTR          (INSTR),
    .INSTR_READY    (INSTR_READY),
    .READ_DATA_ONE  (READ_DATA_ONE),
    .READ_DATA_TWO  (READ_DATA_TWO),
    .REG_SOURCE     (REG_SOURCE),
    .REG_TWO        (REG_TWO),
    .REG_DEST       (REG_DEST),
    .REGDST         (REGDST),
    .REGWRITE       (REGWRITE),
    .REG_WRITE_DATA (REG_WRITE_DATA),
    .CARRY          (CARRY),
    .DONE           (DONE),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  // Register file: writes are not gated by RST so a WB in flight still lands
  logic [7:0] rf [4] = '{default: 8'h00};
  logic [7:0] rd1_pipe [READ_LAT];
  logic [7:0] rd2_pipe [READ_LAT];

  always @(posedge CLK) begin
    if (REGWRITE) rf[REGDST ? REG_DEST : REG_TWO] <= REG_WRITE_DATA;
    rd1_pipe[0] <= rf[REG_SOURCE];
    rd2_pipe[0] <= rf[REG_TWO];
    for (int i = 1; i < READ_LAT; i++) begin
      rd1_pipe[i] <= rd1_pipe[i-1];
      rd2_pipe[i] <= rd2_pipe[i-1];
    end
  end

  assign READ_DATA_ONE = rd1_pipe[READ_LAT-1];
  assign READ_DATA_TWO = rd2_pipe[READ_LAT-1];

  int         cyc = 0;
  int         chk_cnt = 0;
  int         err_cnt = 0;
  int         rd_idx = 0;
  sb_t        sb_q[$];
  sb_t        mon_e;
  logic [7:0] prog_q[$];
  logic [7:0] mrf [4];
  logic       mcarry;
  logic       wr_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of one instruction against the model register file
  function automatic sb_t model_exec(input logic [7:0] ins);
    sb_t        e;
    logic [8:0] s;
    logic [7:0] a, b, imm;
    a        = mrf[ins[5:4]];
    b        = mrf[ins[3:2]];
    e.rs     = ins[5:4];
    e.acc    = 0;
    e.wr     = 1'b1;
    e.regdst = 1'b1;
    e.addr   = ins[1:0];
    e.data   = 8'h00;
    e.carry  = mcarry;
    case (ins[7:6])
      2'b00: begin s = {1'b0, a} + {1'b0, b}; e.data = s[7:0]; e.carry = s[8]; end
      2'b01: begin e.data = a - b; e.carry = (a < b); end
      2'b10: begin
        case (ins[1:0])
          2'b00:   imm = 8'h00;
          2'b01:   imm = 8'h01;
          2'b10:   imm = 8'hFE;
          default: imm = 8'hFF;
        endcase
        s = {1'b0, a} + {1'b0, imm};
        e.data = s[7:0]; e.carry = s[8]; e.regdst = 1'b0; e.addr = ins[3:2];
      end
      default: begin e.wr = 1'b0; e.regdst = 1'b0; e.addr = 2'b00; e.rs = 2'b00; end
    endcase
    return e;
  endfunction

  // Output monitor: every write-back and DONE is retired against the scoreboard head
  always @(negedge CLK) begin
    if (!RST) begin
      if (REGWRITE) begin
        if (rd_idx >= sb_q.size()) check("unexpected_write", 32'(REGWRITE), 0);
        else begin
          mon_e = sb_q[rd_idx];
          check("wr_en", 32'(REGWRITE), 32'(mon_e.wr));
          check("wr_addr", 32'(REGDST ? REG_DEST : REG_TWO), 32'(mon_e.addr));
          check("wr_regdst", 32'(REGDST), 32'(mon_e.regdst));
          check("wr_rs_held", 32'(REG_SOURCE), 32'(mon_e.rs));
          check("wr_data", 32'(REG_WRITE_DATA), 32'(mon_e.data));
          check("wr_latency", 32'(cyc + 1 - mon_e.acc), 32'(3 + READ_LAT));
          check("wr_while_ready", 32'(INSTR_READY), 0);
          check("wr_busy", 32'(BUSY), 1);
          wr_seen = 1'b1;
        end
      end
      if (DONE) begin
        if (rd_idx >= sb_q.size()) check("unexpected_done", 32'(DONE), 0);
        else begin
          mon_e = sb_q[rd_idx];
          check("done_wrote", 32'(wr_seen), 32'(mon_e.wr));
          check("done_carry", 32'(CARRY), 32'(mon_e.carry));
          check("done_latency", 32'(cyc - mon_e.acc), 32'(3 + READ_LAT));
          check("done_ready", 32'(INSTR_READY), 1);
          wr_seen = 1'b0;
          rd_idx++;
        end
      end
    end
  end

  // Offer prog_q with INSTR_VALID held high; each accept pushes the model's expectation
  task automatic run_prog();
    int   k = 0;
    int   last_acc = -1;
    int   guard = 0;
    int   limit;
    logic ready_s;
    sb_t  e;
    limit = (4 + READ_LAT) * prog_q.size() + 10;
    @(negedge CLK);
    INSTR_VALID = 1'b1;
    INSTR = prog_q[0];
    while (k < prog_q.size() && guard < limit) begin
      ready_s = INSTR_READY;
      @(posedge CLK);
      #1;
      guard++;
      if (ready_s) begin
        e = model_exec(prog_q[k]);
        e.acc = cyc;
        sb_q.push_back(e);
        if (e.wr) mrf[e.addr] = e.data;
        mcarry = e.carry;
        if (last_acc >= 0) check("accept_gap", 32'(cyc - last_acc), 32'(4 + READ_LAT));
        last_acc = cyc;
        k++;
        if (k < prog_q.size()) INSTR = prog_q[k];
        else INSTR_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    if (k < prog_q.size()) check("accept_timeout", 32'(k), 32'(prog_q.size()));
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_idx != sb_q.size() || !INSTR_READY) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60) check("drain_timeout", 32'(rd_idx), 32'(sb_q.size()));
  endtask

  task automatic check_reset(input string tag);
    check(tag, {12'h0, INSTR_READY, BUSY, DONE, REGWRITE, REGDST, CARRY,
                REG_SOURCE, REG_TWO, REG_DEST, REG_WRITE_DATA}, 32'h0008_0000);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 4; i++) check($sformatf("rf%0d", i), 32'(rf[i]), 32'(mrf[i]));
  endtask

  // Accept ins, then assert RST on the n-th falling edge after the accept
  task automatic abort_at(input string tag, input int n_neg, input logic [7:0] ins);
    int wr_cnt = 0;
    @(negedge CLK);
    check({tag, "_ready"}, 32'(INSTR_READY), 1);
    INSTR_VALID = 1'b1;
    INSTR = ins;
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    repeat (n_neg) @(negedge CLK);
    check({tag, "_busy"}, 32'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mcarry = 1'b0;
    check_reset({tag, "_reset_outs"});
    repeat (8) begin
      @(negedge CLK);
      wr_cnt += int'(REGWRITE);
    end
    check({tag, "_no_write"}, 32'(wr_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    mcarry = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset("reset_outs");
    RST = 1'b0;

    // ADDI r1 = r0 + 1
    prog_q = '{8'h85};
    run_prog(); drain();
    check("addi_r1", 32'(rf[1]), 32'h01);

    // ADDI r2 = r0 + (-1); ADD r3 = r1 + r2 wraps to zero with carry
    prog_q = '{8'h8B, 8'h1B};
    run_prog(); drain();
    check("addi_r2", 32'(rf[2]), 32'hFF);
    check("add_wrap", 32'(rf[3]), 32'h00);
    check("add_carry", 32'(CARRY), 1);

    // SUB r3 = r1 - r2 borrows; aliased ADD r1 = r1 + r1
    prog_q = '{8'h5B};
    run_prog(); drain();
    check("sub_r3", 32'(rf[3]), 32'h02);
    check("sub_borrow", 32'(CARRY), 1);
    prog_q = '{8'h15};
    run_prog(); drain();
    check("alias_r1", 32'(rf[1]), 32'h02);

    // Back-to-back stream with NOPs and random instructions
    prog_q = '{8'hC0, 8'h1B, 8'hC0, 8'h66, 8'hAF};
    for (int i = 0; i < 8; i++) prog_q.push_back(8'($urandom_range(0, 255)));
    prog_q.push_back(8'hC0);
    run_prog(); drain();
    check_rf();

    // Reset mid-operation: in WAIT and in EXEC
    abort_at("abort_wait", 2, 8'h1B);
    abort_at("abort_exec", 2 + READ_LAT, 8'h5B);
    check_rf();

    // Recovery after reset
    prog_q = '{8'h85, 8'h5B};
    run_prog(); drain();
    check_rf();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
